alu_reservation_station: RTL and testbench

Reservation station feeding the combinational ALU in the Tomasulo core. It accepts issued ALU/branch/jump instructions from the issue unit and tracks operand readiness through the ROB tags Qj/Qk. It captures operand values from the ALU and LSB broadcast buses, then dispatches one ready instruction per cycle through registered outputs that drive the ALU input port directly.

---
 rtl/alu_reservation_station_pkg.sv | 80 ++++++++
 rtl/alu_reservation_station_rs_priority_select.sv | 29 ++
 rtl/alu_reservation_station.sv | 150 +++++++++++++++
 tb/tb_alu_reservation_station.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared definitions for the ALU reservation station.
// Holds the datapath widths, the opcode encodings dispatched to the ALU,
// the entry/dispatch record layouts and the CDB operand-capture helper.
package alu_reservation_station_pkg;

  localparam int ID_WIDTH        = 32;
  localparam int ROB_WIDTH       = 4;
  localparam int ADDR_WIDTH      = 32;
  localparam int INST_TYPE_WIDTH = 5;

  typedef logic [ID_WIDTH-1:0]        data_t;
  typedef logic [ROB_WIDTH-1:0]       rob_tag_t;
  typedef logic [ADDR_WIDTH-1:0]      addr_t;
  typedef logic [INST_TYPE_WIDTH-1:0] opcode_t;

  // Opcode encodings understood by the ALU; NOP means "no instruction".
  localparam opcode_t OP_NOP   = 5'd0;
  localparam opcode_t OP_ADD   = 5'd1;
  localparam opcode_t OP_SUB   = 5'd2;
  localparam opcode_t OP_XOR   = 5'd3;
  localparam opcode_t OP_OR    = 5'd4;
  localparam opcode_t OP_AND   = 5'd5;
  localparam opcode_t OP_SLL   = 5'd6;
  localparam opcode_t OP_SRL   = 5'd7;
  localparam opcode_t OP_SRA   = 5'd8;
  localparam opcode_t OP_SLT   = 5'd9;
  localparam opcode_t OP_SLTU  = 5'd10;
  localparam opcode_t OP_BEQ   = 5'd11;
  localparam opcode_t OP_BNE   = 5'd12;
  localparam opcode_t OP_BLT   = 5'd13;
  localparam opcode_t OP_BGE   = 5'd14;
  localparam opcode_t OP_BLTU  = 5'd15;
  localparam opcode_t OP_BGEU  = 5'd16;
  localparam opcode_t OP_JAL   = 5'd17;
  localparam opcode_t OP_JALR  = 5'd18;
  localparam opcode_t OP_LUI   = 5'd19;
  localparam opcode_t OP_AUIPC = 5'd20;

  // One source operand: tag q is the producing ROB entry, 0 when v is valid.
  typedef struct packed {
    rob_tag_t q;
    data_t    v;
  } operand_t;

  typedef struct packed {
    opcode_t  opcode;
    operand_t j;
    operand_t k;
    data_t    a;
    addr_t    pc;
    rob_tag_t dest;
  } rs_entry_t;

  typedef struct packed {
    opcode_t  opcode;
    data_t    vj;
    data_t    vk;
    data_t    a;
    addr_t    pc;
    rob_tag_t dest;
  } dispatch_t;

  // Snoop both broadcast buses for a waiting operand. Tag 0 never matches,
  // and the ALU bus wins when both buses carry the same tag.
  function automatic operand_t capture_operand(operand_t op,
                                               rob_tag_t alu_h, data_t alu_v,
                                               rob_tag_t lsb_h, data_t lsb_v);
    operand_t res;
    res = op;
    if (op.q != '0 && op.q == alu_h) begin
      res.q = '0;
      res.v = alu_v;
    end else if (op.q != '0 && op.q == lsb_h) begin
      res.q = '0;
      res.v = lsb_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_reservation_station_rs_priority_select.sv
// Lowest-index set-bit finder.
// Ports:
//   req_in    - request vector
//   found_out - at least one request bit is set
//   idx_out   - index of the lowest set bit (0 when none)
module rs_priority_select #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req_in,
  output logic         found_out,
  output logic [W-1:0] idx_out
);

  // Scanning from the top lets the lowest set bit overwrite the result last.
  // NOTE: every combinational output gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    found_out = 1'b0;
    idx_out   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_in[i]) begin
        found_out = 1'b1;
        idx_out   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station in front of the combinational ALU.
// Accepts issued instructions into the lowest free entry, snoops the ALU and
// LSB broadcast buses for missing operands, and dispatches the lowest-index
// ready entry each cycle into registered outputs wired to the ALU.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global hold when low)
//   iss_rs_*        - issue interface; rs_iss_full_out back-pressures it
//   alu_cdb_*/lsb_cdb_* - broadcast buses (tag 0 = idle)
//   rob_rs_rst_in   - misprediction flush
//   rs_alu_*_out    - registered dispatch to the ALU (opcode NOP when idle)
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int RS_SIZE      = 8,
  parameter int RS_IDX_WIDTH = 3
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       iss_rs_en_in,
  input  logic [INST_TYPE_WIDTH-1:0] iss_rs_opcode_in,
  input  logic [ID_WIDTH-1:0]        iss_rs_vj_in,
  input  logic [ID_WIDTH-1:0]        iss_rs_vk_in,
  input  logic [ROB_WIDTH-1:0]       iss_rs_qj_in,
  input  logic [ROB_WIDTH-1:0]       iss_rs_qk_in,
  input  logic [ID_WIDTH-1:0]        iss_rs_a_in,
  input  logic [ADDR_WIDTH-1:0]      iss_rs_pc_in,
  input  logic [ROB_WIDTH-1:0]       iss_rs_dest_in,
  output logic                       rs_iss_full_out,
  input  logic [ROB_WIDTH-1:0]       alu_cdb_h_in,
  input  logic [ID_WIDTH-1:0]        alu_cdb_result_in,
  input  logic [ROB_WIDTH-1:0]       lsb_cdb_h_in,
  input  logic [ID_WIDTH-1:0]        lsb_cdb_result_in,
  input  logic                       rob_rs_rst_in,
  output logic [INST_TYPE_WIDTH-1:0] rs_alu_opcode_out,
  output logic [ID_WIDTH-1:0]        rs_alu_vj_out,
  output logic [ID_WIDTH-1:0]        rs_alu_vk_out,
  output logic [ID_WIDTH-1:0]        rs_alu_a_out,
  output logic [ADDR_WIDTH-1:0]      rs_alu_pc_out,
  output logic [ROB_WIDTH-1:0]       rs_alu_dest_out
);

  logic [RS_SIZE-1:0]      busy_q, busy_d;
  rs_entry_t               entry_q [RS_SIZE];
  rs_entry_t               entry_d [RS_SIZE];
  dispatch_t               disp_q, disp_d;

  logic [RS_SIZE-1:0]      ready_vec;
  logic                    free_found, ready_found;
  logic [RS_IDX_WIDTH-1:0] free_idx, ready_idx;

  // Readiness and free slots come from registered state only, so an entry
  // woken or issued at an edge is first eligible at the following edge, and
  // a slot freed by dispatch is not reused in the same cycle.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy_q[i] && (entry_q[i].j.q == '0) && (entry_q[i].k.q == '0);
    end
  end

  rs_priority_select #(.N(RS_SIZE), .W(RS_IDX_WIDTH)) u_free_sel (
    .req_in    (~busy_q),
    .found_out (free_found),
    .idx_out   (free_idx)
  );

  rs_priority_select #(.N(RS_SIZE), .W(RS_IDX_WIDTH)) u_ready_sel (
    .req_in    (ready_vec),
    .found_out (ready_found),
    .idx_out   (ready_idx)
  );

  assign rs_iss_full_out = &busy_q;

  always_comb begin
    busy_d  = busy_q;
    entry_d = entry_q;
    disp_d  = disp_q;
    if (rdy_in) begin
      if (rob_rs_rst_in) begin
        busy_d        = '0;
        disp_d.opcode = OP_NOP;
        disp_d.dest   = '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i]) begin
            entry_d[i].j = capture_operand(entry_q[i].j, alu_cdb_h_in, alu_cdb_result_in,
                                           lsb_cdb_h_in, lsb_cdb_result_in);
            entry_d[i].k = capture_operand(entry_q[i].k, alu_cdb_h_in, alu_cdb_result_in,
                                           lsb_cdb_h_in, lsb_cdb_result_in);
          end
        end

        if (ready_found) begin
          disp_d.opcode     = entry_q[ready_idx].opcode;
          disp_d.vj         = entry_q[ready_idx].j.v;
          disp_d.vk         = entry_q[ready_idx].k.v;
          disp_d.a          = entry_q[ready_idx].a;
          disp_d.pc         = entry_q[ready_idx].pc;
          disp_d.dest       = entry_q[ready_idx].dest;
          busy_d[ready_idx] = 1'b0;
        end else begin
          disp_d.opcode = OP_NOP;
          disp_d.dest   = '0;
        end

        // The free slot is never the dispatching slot: one is busy, one is not.
        if (iss_rs_en_in && free_found) begin
          entry_d[free_idx].opcode = iss_rs_opcode_in;
          entry_d[free_idx].j      = capture_operand('{q: iss_rs_qj_in, v: iss_rs_vj_in},
                                                     alu_cdb_h_in, alu_cdb_result_in,
                                                     lsb_cdb_h_in, lsb_cdb_result_in);
          entry_d[free_idx].k      = capture_operand('{q: iss_rs_qk_in, v: iss_rs_vk_in},
                                                     alu_cdb_h_in, alu_cdb_result_in,
                                                     lsb_cdb_h_in, lsb_cdb_result_in);
          entry_d[free_idx].a      = iss_rs_a_in;
          entry_d[free_idx].pc     = iss_rs_pc_in;
          entry_d[free_idx].dest   = iss_rs_dest_in;
          busy_d[free_idx]         = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the values from before the edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      disp_q <= '{opcode: OP_NOP, default: '0};
    end else begin
      busy_q <= busy_d;
      disp_q <= disp_d;
    end
  end

  // NOTE: entry payloads are deliberately not reset; a payload is only ever
  // read while its busy bit is set, and busy is reset.
  always_ff @(posedge clk_in) begin
    entry_q <= entry_d;
  end

  assign rs_alu_opcode_out = disp_q.opcode;
  assign rs_alu_vj_out     = disp_q.vj;
  assign rs_alu_vk_out     = disp_q.vk;
  assign rs_alu_a_out      = disp_q.a;
  assign rs_alu_pc_out     = disp_q.pc;
  assign rs_alu_dest_out   = disp_q.dest;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed scenarios with
// literal expectations, then randomized traffic checked every cycle against
// a slot-array model of the station.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, iss_en, flush;
  logic [4:0]  iss_op;
  logic [31:0] iss_vj, iss_vk, iss_a, iss_pc;
  logic [3:0]  iss_qj, iss_qk, iss_dest;
  logic [3:0]  alu_h, lsb_h;
  logic [31:0] alu_res, lsb_res;
  logic        full_out;
  logic [4:0]  op_out;
  logic [31:0] vj_out, vk_out, a_out, pc_out;
  logic [3:0]  dest_out;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  alu_reservation_station #(.RS_SIZE(8), .RS_IDX_WIDTH(3)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .iss_rs_en_in      (iss_en),
    .iss_rs_opcode_in  (iss_op),
    .iss_rs_vj_in      (iss_vj),
    .iss_rs_vk_in      (iss_vk),
    .iss_rs_qj_in      (iss_qj),
    .iss_rs_qk_in      (iss_qk),
    .iss_rs_a_in       (iss_a),
    .iss_rs_pc_in      (iss_pc),
    .iss_rs_dest_in    (iss_dest),
    .rs_iss_full_out   (full_out),
    .alu_cdb_h_in      (alu_h),
    .alu_cdb_result_in (alu_res),
    .lsb_cdb_h_in      (lsb_h),
    .lsb_cdb_result_in (lsb_res),
    .rob_rs_rst_in     (flush),
    .rs_alu_opcode_out (op_out),
    .rs_alu_vj_out     (vj_out),
    .rs_alu_vk_out     (vk_out),
    .rs_alu_a_out      (a_out),
    .rs_alu_pc_out     (pc_out),
    .rs_alu_dest_out   (dest_out)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit          busy;
    logic [4:0]  op;
    logic [31:0] vj, vk, a, pc;
    logic [3:0]  qj, qk, dest;
  } slot_t;

  slot_t       m [8];
  bit          m_full;
  bit          exp_fields;   // whether vj/vk/a/pc are defined this cycle
  logic [4:0]  exp_op;
  logic [31:0] exp_vj, exp_vk, exp_a, exp_pc;
  logic [3:0]  exp_dest;

  function automatic logic [35:0] snoop(logic [3:0] q, logic [31:0] v);
    if (q != 0 && q == alu_h) return {4'd0, alu_res};
    if (q != 0 && q == lsb_h) return {4'd0, lsb_res};
    return {q, v};
  endfunction

  task automatic model_step();
    int disp = -1;
    int free = -1;
    if (rst_in) begin
      foreach (m[i]) m[i].busy = 0;
      exp_op = OP_NOP; exp_dest = 0;
      exp_vj = 0; exp_vk = 0; exp_a = 0; exp_pc = 0;
      exp_fields = 1;
    end else if (!rdy_in) begin
      // everything holds
    end else if (flush) begin
      foreach (m[i]) m[i].busy = 0;
      exp_op = OP_NOP; exp_dest = 0;
      exp_fields = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (disp < 0 && m[i].busy && m[i].qj == 0 && m[i].qk == 0) disp = i;
        if (free < 0 && !m[i].busy) free = i;
      end
      for (int i = 0; i < 8; i++) begin
        if (m[i].busy) begin
          {m[i].qj, m[i].vj} = snoop(m[i].qj, m[i].vj);
          {m[i].qk, m[i].vk} = snoop(m[i].qk, m[i].vk);
        end
      end
      if (disp >= 0) begin
        exp_op = m[disp].op; exp_vj = m[disp].vj; exp_vk = m[disp].vk;
        exp_a = m[disp].a; exp_pc = m[disp].pc; exp_dest = m[disp].dest;
        exp_fields = 1;
        m[disp].busy = 0;
      end else begin
        exp_op = OP_NOP; exp_dest = 0; exp_fields = 0;
      end
      if (iss_en && free >= 0) begin
        m[free].busy = 1;
        m[free].op = iss_op; m[free].a = iss_a; m[free].pc = iss_pc;
        m[free].dest = iss_dest;
        {m[free].qj, m[free].vj} = snoop(iss_qj, iss_vj);
        {m[free].qk, m[free].vk} = snoop(iss_qk, iss_vk);
      end
    end
    m_full = 1;
    foreach (m[i]) if (!m[i].busy) m_full = 0;
  endtask

  // ---------------- checking ----------------
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("full", full_out, m_full);
    check("opcode", op_out, exp_op);
    check("dest", dest_out, exp_dest);
    if (exp_fields) begin
      check("vj", vj_out, exp_vj);
      check("vk", vk_out, exp_vk);
      check("a", a_out, exp_a);
      check("pc", pc_out, exp_pc);
    end
  endtask

  // The issue unit must never issue into a full station.
  always @(posedge clk_in) begin
    if (!rst_in && rdy_in && !flush)
      assert (!(iss_en && full_out)) else $error("issue while station full");
  end

  // Inputs are applied at the negedge; the model is advanced with those
  // inputs, then outputs are compared 1 time unit after the rising edge.
  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
    compare_all();
    @(negedge clk_in);
  endtask

  task automatic idle();
    rst_in = 0; rdy_in = 1; iss_en = 0; flush = 0;
    iss_op = OP_NOP; iss_vj = 0; iss_vk = 0; iss_qj = 0; iss_qk = 0;
    iss_a = 0; iss_pc = 0; iss_dest = 0;
    alu_h = 0; alu_res = 0; lsb_h = 0; lsb_res = 0;
  endtask

  task automatic issue(logic [4:0] op, logic [31:0] vj, logic [3:0] qj,
                       logic [31:0] vk, logic [3:0] qk, logic [3:0] dest);
    iss_en = 1; iss_op = op; iss_vj = vj; iss_qj = qj; iss_vk = vk; iss_qk = qk;
    iss_dest = dest; iss_a = 32'h100 + 32'(dest); iss_pc = 32'h8000 + 32'(dest) * 4;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    // Reset held for two edges.
    rst_in = 1;
    tick(); tick();
    check("reset_opcode", op_out, OP_NOP);
    check("reset_dest", dest_out, 0);
    check("reset_full", full_out, 0);
    idle();

    // Ready issue: dispatched after one edge, then NOP.
    issue(OP_ADD, 5, 0, 7, 0, 3);
    tick();
    idle();
    tick();
    check("ready_op", op_out, OP_ADD);
    check("ready_vj", vj_out, 5);
    check("ready_vk", vk_out, 7);
    check("ready_dest", dest_out, 3);
    tick();
    check("ready_then_nop", op_out, OP_NOP);

    // Wakeup through the ALU bus.
    issue(OP_SUB, 0, 2, 1, 0, 4);
    tick();
    idle();
    tick();
    check("wait_nop", op_out, OP_NOP);
    alu_h = 2; alu_res = 32'h10;
    tick();
    check("wake_edge_nop", op_out, OP_NOP);
    idle();
    tick();
    check("wake_op", op_out, OP_SUB);
    check("wake_vj", vj_out, 32'h10);
    check("wake_vk", vk_out, 1);
    check("wake_dest", dest_out, 4);

    // Issue-time bypass from the LSB bus.
    issue(OP_XOR, 3, 0, 0, 6, 5);
    lsb_h = 6; lsb_res = 32'hFF;
    tick();
    idle();
    tick();
    check("bypass_op", op_out, OP_XOR);
    check("bypass_vk", vk_out, 32'hFF);
    check("bypass_dest", dest_out, 5);

    // Fill all entries, then release them with one broadcast.
    for (int d = 1; d <= 8; d++) begin
      issue(OP_ADD, 0, 9, 32'(d), 0, 4'(d));
      tick();
    end
    idle();
    check("full_set", full_out, 1);
    alu_h = 9; alu_res = 32'h55;
    tick();
    idle();
    for (int d = 1; d <= 8; d++) begin
      tick();
      check("order_dest", dest_out, d);
      if (d == 1) check("full_clear", full_out, 0);
    end
    tick();
    check("drained_nop", op_out, OP_NOP);

    // Flush with waiting entries, a ready entry and a pending issue.
    for (int d = 1; d <= 3; d++) begin
      issue(OP_OR, 0, 9, 0, 0, 4'(d));
      tick();
    end
    issue(OP_AND, 1, 0, 2, 0, 7);
    tick();
    issue(OP_ADD, 1, 0, 1, 0, 10);
    flush = 1;
    tick();
    check("flush_full", full_out, 0);
    check("flush_op", op_out, OP_NOP);
    check("flush_dest", dest_out, 0);
    idle();
    alu_h = 9; alu_res = 32'h77;
    tick();
    idle();
    for (int n = 0; n < 3; n++) begin
      tick();
      check("post_flush_op", op_out, OP_NOP);
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst_in  = ($urandom_range(0, 299) == 0);
      rdy_in  = ($urandom_range(0, 9) != 0);
      flush   = ($urandom_range(0, 59) == 0);
      iss_en  = ($urandom_range(0, 2) != 0) && !m_full;
      iss_op  = 5'($urandom_range(1, 20));
      iss_vj  = $urandom;
      iss_vk  = $urandom;
      iss_qj  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0;
      iss_qk  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0;
      iss_a   = $urandom;
      iss_pc  = $urandom;
      iss_dest = 4'($urandom_range(1, 15));
      alu_h   = 4'($urandom_range(0, 7));
      alu_res = $urandom;
      lsb_h   = 4'($urandom_range(0, 7));
      lsb_res = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
